ca_status_driver: RTL
=====================

CA_STATUS_DRIVER -- requirements
Module: ca_status_driver

Interface
REQ-001 Parameter MAX_STEPS, default 256: maximum records issued before giving up; legal range 2..256.
REQ-002 Parameter CHK_WAIT, default 1: cycles from cmp_stb until cycle_hit is sampled; legal range 1..4.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
REQ-006 abort  in  1  level; forces DONE from any busy state.
REQ-007 seed  in  8  initial status, captured on an accepted start.
REQ-008 rule  in  8  elementary cellular-automaton rule number, captured on an accepted start.
REQ-009 status  out  8  current status vector presented to the checker.
REQ-010 clr_stb  out  1  one-cycle pulse that clears the checker history.
REQ-011 cmp_stb  out  1  one-cycle pulse: checker compares status against its history.
REQ-012 rec_stb  out  1  one-cycle pulse: checker appends status to its history.
REQ-013 cycle_hit  in  1  checker verdict, sticky until clr_stb.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high in DONE.
REQ-016 hit  out  1  valid when done: 1 = repeat found, 0 = MAX_STEPS exhausted or aborted.
REQ-017 steps  out  9  number of rec_stb pulses issued in the current run.

Function
REQ-018 FSM states: IDLE, CLEAR, COMPARE, WAIT, RECORD, STEP, DONE.
REQ-019 IDLE/DONE + start -> CLEAR; latch seed into status and rule into rule_q; clear steps and hit.
REQ-020 CLEAR: assert clr_stb for one cycle -> COMPARE.
REQ-021 COMPARE: assert cmp_stb for one cycle -> WAIT.
REQ-022 WAIT: hold for CHK_WAIT cycles, then sample cycle_hit; if 1, set hit and go -> DONE; otherwise -> RECORD.
REQ-023 RECORD: assert rec_stb for one cycle and increment steps; if the new steps value equals MAX_STEPS -> DONE with hit=0; otherwise -> STEP.
REQ-024 STEP: status[i] <= rule_q[{status[(i+1)%8], status[i], status[(i+7)%8]}] for i=0..7, where bit 0 is the LSB and both ends wrap circularly -> COMPARE.
REQ-025 status SHALL be stable from COMPARE through the end of RECORD.
REQ-026 Strobes SHALL be mutually exclusive and never asserted in IDLE or DONE.
REQ-027 abort has priority over every transition; it forces DONE with hit=0, and no strobe is issued in the abort cycle.
REQ-028 start while busy SHALL be ignored; start and abort in the same cycle SHALL leave the block in DONE.
REQ-029 steps SHALL saturate at MAX_STEPS and never wrap.
REQ-030 done/hit/status/steps SHALL hold in DONE until the next accepted start.

Reset
REQ-031 Asynchronous reset_n low: state=IDLE, status=0x00, rule_q=0x00, steps=0, all strobes=0, busy=0, done=0, hit=0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no further strobes; deassertion SHALL not start a run without start.

Structure
REQ-033 FSM state enum, STATUS_W=8, and STEPS_W=9 SHALL live in shared package ca_pkg for use by the checker side.
REQ-034 The next-state function SHALL be the combinational sub-module ca_rule_step (in: status, rule; out: next).

Verification (bench pairs the DUT with a behavioural 256-entry history model)
REQ-035 rule=0x00, seed=0x01, start -> statuses 0x01, 0x00, 0x00; done with hit=1, steps=2.
REQ-036 rule=0xCC (identity), seed=0xA5 -> second compare hits; hit=1, steps=1, status=0xA5.
REQ-037 rule=0x33 (complement), seed=0x0F -> 0x0F, 0xF0, 0x0F; hit=1, steps=2.
REQ-038 MAX_STEPS=4 with a model that never hits -> exactly 4 rec_stb pulses; done with hit=0, steps=4.
REQ-039 abort asserted in WAIT of step 3 -> DONE next cycle with hit=0, steps=2 and no further strobes; a later start restarts with clr_stb.
REQ-040 reset_n low during RECORD -> all outputs reach reset values immediately; start issued while busy is ignored.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared types and widths for the cellular-automaton status driver and its checker.
package ca_pkg;
   localparam int STATUS_W = 8;
   localparam int STEPS_W  = 9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_COMPARE,
      ST_WAIT,
      ST_RECORD,
      ST_STEP,
      ST_DONE
   } ca_state_e;
endpackage

// File: rtl/ca_rule_step.sv
// One elementary-CA generation on a circular status ring, bit 0 = LSB.
module ca_rule_step
   import ca_pkg::*;
(
   input  logic [STATUS_W-1:0] status_i,
   input  logic [7:0]          rule_i,
   output logic [STATUS_W-1:0] next_o
);
   // Neighbourhood index is {upper neighbour, self, lower neighbour}, wrapping at both ends.
   for (genvar i = 0; i < STATUS_W; i++) begin : g_cell
      assign next_o[i] = rule_i[{status_i[(i + 1) % STATUS_W],
                                 status_i[i],
                                 status_i[(i + STATUS_W - 1) % STATUS_W]}];
   end
endmodule

// File: rtl/ca_status_driver.sv
// Walks a CA trajectory, strobing an external history checker until a repeat,
// MAX_STEPS records, or abort.
module ca_status_driver
   import ca_pkg::*;
#(
   parameter int MAX_STEPS = 256,
   parameter int CHK_WAIT  = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [STATUS_W-1:0] seed,
   input  logic [7:0]          rule,
   output logic [STATUS_W-1:0] status,
   output logic                clr_stb,
   output logic                cmp_stb,
   output logic                rec_stb,
   input  logic                cycle_hit,
   output logic                busy,
   output logic                done,
   output logic                hit,
   output logic [STEPS_W-1:0]  steps
);
   localparam logic [STEPS_W-1:0] MAX_S     = STEPS_W'(MAX_STEPS);
   localparam logic [1:0]         WAIT_LAST = 2'(CHK_WAIT - 1);

   ca_state_e           state_q;
   logic [STATUS_W-1:0] status_q, status_d;
   logic [7:0]          rule_q;
   logic [STEPS_W-1:0]  steps_q, steps_d;
   logic                hit_q;
   logic [1:0]          wcnt_q;

   ca_rule_step u_step (
      .status_i (status_q),
      .rule_i   (rule_q),
      .next_o   (status_d)
   );

   assign steps_d = steps_q + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         status_q <= '0;
         rule_q   <= '0;
         steps_q  <= '0;
         hit_q    <= 1'b0;
         wcnt_q   <= '0;
      end else if (abort && busy) begin
         state_q <= ST_DONE;
         hit_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start && abort) begin
                  state_q <= ST_DONE;
               end else if (start) begin
                  state_q  <= ST_CLEAR;
                  status_q <= seed;
                  rule_q   <= rule;
                  steps_q  <= '0;
                  hit_q    <= 1'b0;
               end
            end
            ST_CLEAR:   state_q <= ST_COMPARE;
            ST_COMPARE: begin
               state_q <= ST_WAIT;
               wcnt_q  <= '0;
            end
            ST_WAIT: begin
               if (wcnt_q == WAIT_LAST) begin
                  if (cycle_hit) begin
                     hit_q   <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_RECORD;
                  end
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
            end
            // Stopping exactly at MAX_S is what keeps steps from ever wrapping.
            ST_RECORD: begin
               steps_q <= steps_d;
               state_q <= (steps_d == MAX_S) ? ST_DONE : ST_STEP;
            end
            ST_STEP: begin
               status_q <= status_d;
               state_q  <= ST_COMPARE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy    = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign done    = (state_q == ST_DONE);
   assign hit     = hit_q;
   assign status  = status_q;
   assign steps   = steps_q;
   // An abort cycle suppresses the strobe of whatever state it lands in.
   assign clr_stb = (state_q == ST_CLEAR)   && !abort;
   assign cmp_stb = (state_q == ST_COMPARE) && !abort;
   assign rec_stb = (state_q == ST_RECORD)  && !abort;
endmodule
